// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline registers: load-use, ERET/EPC
// and mult/div hazards, with exceptions taken at M overriding every stall.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       e_load,
  input  logic [4:0] e_wa,
  input  logic       d_md,
  input  logic       e_md_start,
  input  logic       e_md_div,
  input  logic       d_eret,
  input  logic       e_mtc0_epc,
  input  logic       m_mtc0_epc,
  input  logic       exc_m,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic       flush_all,
  output logic       eret_go,
  output logic       md_busy
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYC);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] md_count;
  logic          start_ok;
  logic          haz_lu;
  logic          haz_md;
  logic          haz_epc;
  logic          stall;

  // A start squashed by an exception at M never reaches the unit.
  assign start_ok = e_md_start & ~exc_m;

  // An op already running keeps counting through exceptions so it completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      md_count <= '0;
    end else begin
      if (start_ok) begin
        md_count <= e_md_div ? DIV_LOAD : MULT_LOAD;
        state    <= MD_WAIT;
      end else if (md_count != '0) begin
        md_count <= md_count - CNT_ONE;
        if (md_count == CNT_ONE) begin
          state <= RUN;
        end
      end
    end
  end

  assign md_busy = (state == MD_WAIT) && (md_count != '0);

  assign haz_lu  = e_load && (e_wa != 5'd0) &&
                   ((d_use_rs && (d_rs == e_wa)) || (d_use_rt && (d_rt == e_wa)));
  assign haz_md  = d_md & (md_busy | e_md_start);
  assign haz_epc = d_eret & (e_mtc0_epc | m_mtc0_epc);
  assign stall   = haz_lu | haz_md | haz_epc;

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_e   = 1'b0;
    flush_all = 1'b0;
    eret_go   = 1'b0;
    if (exc_m) begin
      flush_all = 1'b1;
    end else if (stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (d_eret) begin
      eret_go = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic
// checked against a cycle-level model of the hazard and mult/div busy rules.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_use_rs, d_use_rt;
  logic [4:0] d_rs, d_rt, e_wa;
  logic       e_load, d_md, e_md_start, e_md_div;
  logic       d_eret, e_mtc0_epc, m_mtc0_epc, exc_m;
  logic       stall_f, stall_d, flush_e, flush_all, eret_go, md_busy;

  int checks = 0;
  int errors = 0;
  int md_left = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_rs(d_rs), .d_rt(d_rt),
    .e_load(e_load), .e_wa(e_wa), .d_md(d_md),
    .e_md_start(e_md_start), .e_md_div(e_md_div),
    .d_eret(d_eret), .e_mtc0_epc(e_mtc0_epc), .m_mtc0_epc(m_mtc0_epc),
    .exc_m(exc_m),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .flush_all(flush_all), .eret_go(eret_go), .md_busy(md_busy)
  );

  // Output vector order: {stall_f, stall_d, flush_e, flush_all, eret_go, md_busy}
  task automatic check_output(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model_expect();
    bit busy, hz, lu;
    busy = (md_left > 0);
    lu   = e_load && e_wa != 0 && ((d_use_rs && d_rs == e_wa) || (d_use_rt && d_rt == e_wa));
    hz   = lu || (d_md && (busy || e_md_start)) || (d_eret && (e_mtc0_epc || m_mtc0_epc));
    if (exc_m)       return {5'b00010, busy};
    else if (hz)     return {5'b11100, busy};
    else if (d_eret) return {5'b00001, busy};
    else             return {5'b00000, busy};
  endfunction

  function automatic void model_clock();
    if (reset) md_left = 0;
    else if (e_md_start && !exc_m) md_left = e_md_div ? 10 : 5;
    else if (md_left > 0) md_left--;
  endfunction

  task automatic clear_inputs();
    reset = 0; d_use_rs = 0; d_use_rt = 0; d_rs = 0; d_rt = 0; e_wa = 0;
    e_load = 0; d_md = 0; e_md_start = 0; e_md_div = 0;
    d_eret = 0; e_mtc0_epc = 0; m_mtc0_epc = 0; exc_m = 0;
  endtask

  // Inputs are set around the falling edge; check settles, then one clock passes.
  task automatic apply_stimulus(input string tag);
    #1;
    check_output(tag, {stall_f, stall_d, flush_e, flush_all, eret_go, md_busy}, model_expect());
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic check_literal(input string tag, input logic [5:0] exp);
    #1;
    check_output(tag, {stall_f, stall_d, flush_e, flush_all, eret_go, md_busy}, exp);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    @(negedge clk);
    @(posedge clk); model_clock();
    @(negedge clk);
    reset = 0;
    check_literal("reset_state", 6'b000000);
    apply_stimulus("reset_model");

    // Load-use on rs, then no destination
    e_load = 1; e_wa = 8; d_use_rs = 1; d_rs = 8;
    check_literal("lu_rs_stall", 6'b111000);
    apply_stimulus("lu_rs_model");
    e_wa = 0;
    check_literal("lu_wa0", 6'b000000);
    apply_stimulus("lu_wa0_model");
    clear_inputs();
    e_load = 1; e_wa = 3; d_use_rt = 1; d_rt = 3; d_rs = 3;
    apply_stimulus("lu_rt");
    d_use_rt = 0;
    check_literal("lu_rs_unused", 6'b000000);
    clear_inputs();

    // Mult then mflo
    e_md_start = 1; d_md = 1;
    check_literal("mult_t0", 6'b111000);
    apply_stimulus("mult_t0_model");
    e_md_start = 0;
    for (int t = 1; t <= 5; t++) begin
      check_literal($sformatf("mult_t%0d", t), 6'b111001);
      apply_stimulus($sformatf("mult_t%0d_model", t));
    end
    check_literal("mult_t6", 6'b000000);
    apply_stimulus("mult_t6_model");
    clear_inputs();

    // Div interrupted by reset at t4
    e_md_start = 1; e_md_div = 1;
    apply_stimulus("div_t0");
    clear_inputs();
    for (int t = 1; t <= 3; t++) begin
      check_literal($sformatf("div_t%0d", t), 6'b000001);
      apply_stimulus($sformatf("div_t%0d_model", t));
    end
    reset = 1;
    apply_stimulus("div_t4_reset");
    reset = 0;
    check_literal("div_t5_after_reset", 6'b000000);
    apply_stimulus("div_t5_model");

    // Full div length
    e_md_start = 1; e_md_div = 1;
    apply_stimulus("div_full_t0");
    clear_inputs();
    for (int t = 1; t <= 11; t++) apply_stimulus($sformatf("div_full_t%0d", t));

    // Exception during load-use
    e_load = 1; e_wa = 8; d_use_rs = 1; d_rs = 8; exc_m = 1;
    check_literal("exc_over_lu", 6'b000100);
    apply_stimulus("exc_over_lu_model");
    clear_inputs();

    // ERET after mtc0 EPC
    d_eret = 1; m_mtc0_epc = 1;
    check_literal("eret_epc_stall", 6'b111000);
    apply_stimulus("eret_epc_model");
    m_mtc0_epc = 0;
    check_literal("eret_go", 6'b000010);
    apply_stimulus("eret_go_model");
    clear_inputs();

    // Exception squashes a mult start
    e_md_start = 1; exc_m = 1;
    check_literal("exc_start_flush", 6'b000100);
    apply_stimulus("exc_start_model");
    clear_inputs();
    check_literal("exc_start_no_busy", 6'b000000);
    apply_stimulus("exc_start_no_busy_model");

    // Randomized traffic, small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      d_use_rs   = 1'($urandom);
      d_use_rt   = 1'($urandom);
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      e_wa       = 5'($urandom_range(0, 3));
      e_load     = 1'($urandom);
      d_md       = ($urandom_range(0, 3) == 0);
      e_md_start = (md_left == 0) && ($urandom_range(0, 5) == 0);
      e_md_div   = 1'($urandom);
      d_eret     = ($urandom_range(0, 4) == 0);
      e_mtc0_epc = ($urandom_range(0, 3) == 0);
      m_mtc0_epc = ($urandom_range(0, 3) == 0);
      exc_m      = ($urandom_range(0, 9) == 0);
      reset      = ($urandom_range(0, 49) == 0);
      apply_stimulus($sformatf("rand_%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
